// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C bus arbiter.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  // Open-drain drive encoding used on every SCL/SDA drive signal.
  localparam logic DRIVE_LOW = 1'b0;
  localparam logic RELEASE   = 1'b1;

  // Width of a client index; never narrower than one bit.
  function automatic int CLIENT_INDEX_WIDTH(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/i2c_bus_arbiter_picker.sv
// Round-robin picker: first asserted request starting at the pointer, with wrap.
module round_robin_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] index_o,
  output logic          valid_o
);

  // Walk pointer, pointer+1, ... modulo N and take the first hit.
  always_comb begin
    int j;
    logic [IW-1:0] jj;
    onehot_o = '0;
    index_o  = '0;
    valid_o  = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!valid_o && req_i[jj]) begin
        valid_o      = 1'b1;
        onehot_o[jj] = 1'b1;
        index_o      = jj;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin owner of a shared open-drain I2C bus with idle gap and watchdog.
module i2c_bus_arbiter
  import i2c_pkg::*;
#(
  parameter int CLIENT_COUNT    = 4,
  parameter int IDLE_GAP_CYCLES = 500,
  parameter int TIMEOUT_CYCLES  = 0
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic [CLIENT_COUNT-1:0]                   request,
  output logic [CLIENT_COUNT-1:0]                   grant,
  input  logic [CLIENT_COUNT-1:0]                   client_scl_output,
  input  logic [CLIENT_COUNT-1:0]                   client_sda_output,
  input  logic                                      scl_input,
  input  logic                                      sda_input,
  output logic                                      scl_output,
  output logic                                      sda_output,
  output logic                                      busy,
  output logic [CLIENT_INDEX_WIDTH(CLIENT_COUNT)-1:0] owner,
  output logic                                      timeout
);

  localparam int IW = CLIENT_INDEX_WIDTH(CLIENT_COUNT);

  arb_state_e              state_q, state_d;
  logic [CLIENT_COUNT-1:0] grant_q, grant_d;
  logic [CLIENT_COUNT-1:0] lockout_q, lockout_d;
  logic [IW-1:0]           owner_q, owner_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic                    timeout_q, timeout_d;
  logic [31:0]             hold_q, hold_d;
  logic [31:0]             gap_q, gap_d;

  logic [CLIENT_COUNT-1:0] pick_onehot;
  logic [IW-1:0]           pick_index;
  logic                    pick_valid;
  logic [IW-1:0]           next_ptr;
  logic                    bus_idle;

  round_robin_picker #(.N(CLIENT_COUNT), .IW(IW)) u_picker (
    .req_i    (request & ~lockout_q),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .index_o  (pick_index),
    .valid_o  (pick_valid)
  );

  assign next_ptr = (owner_q == IW'(CLIENT_COUNT - 1)) ? '0 : owner_q + IW'(1);
  assign bus_idle = scl_input && sda_input;

  // Register all arbiter state; reset abandons any transfer in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      lockout_q <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      lockout_q <= lockout_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
    end
  end

  // Next-state: grant from IDLE, release or watchdog from OWNED, idle gap in GAP.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    timeout_d = 1'b0;
    // A low request always clears that client's lockout.
    lockout_d = lockout_q & request;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = OWNED;
          grant_d = pick_onehot;
          owner_d = pick_index;
          hold_d  = '0;
        end
      end
      OWNED: begin
        if (hold_q != '1) hold_d = hold_q + 32'd1;
        // Voluntary release wins over the watchdog in the same cycle.
        if (!request[owner_q]) begin
          state_d = GAP;
          grant_d = '0;
          ptr_d   = next_ptr;
          gap_d   = '0;
        end else if (TIMEOUT_CYCLES != 0 && hold_q == 32'(TIMEOUT_CYCLES - 1)) begin
          state_d            = GAP;
          grant_d            = '0;
          ptr_d              = next_ptr;
          gap_d              = '0;
          lockout_d[owner_q] = 1'b1;
          timeout_d          = 1'b1;
        end
      end
      GAP: begin
        if (!bus_idle) begin
          gap_d = '0;
        end else if (gap_q == 32'(IDLE_GAP_CYCLES - 1)) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign grant      = grant_q;
  assign owner      = owner_q;
  assign timeout    = timeout_q;
  assign busy       = (state_q == OWNED);
  // Only the owner reaches the pins; everything else sees a released bus.
  assign scl_output = busy ? client_scl_output[owner_q] : RELEASE;
  assign sda_output = busy ? client_sda_output[owner_q] : RELEASE;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed vector table plus hand sequences for the I2C bus arbiter.
module tb_i2c_bus_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] request, grant, cscl, csda;
  logic       scl_in, sda_in, scl_out, sda_out, busy, timeout;
  logic [1:0] owner;

  int tests = 0;
  int fails = 0;

  i2c_bus_arbiter #(.CLIENT_COUNT(4), .IDLE_GAP_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
    .clock(clock), .reset(reset), .request(request), .grant(grant),
    .client_scl_output(cscl), .client_sda_output(csda),
    .scl_input(scl_in), .sda_input(sda_in),
    .scl_output(scl_out), .sda_output(sda_out),
    .busy(busy), .owner(owner), .timeout(timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] req, cscl, csda;
    logic       si, di;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy, scl, sda;
  } vec_t;

  vec_t vt[$];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] r, input logic [3:0] c, input logic [3:0] d,
                     input logic si, input logic di, input logic [3:0] g,
                     input logic [1:0] o, input logic b, input logic s, input logic a);
    vec_t v;
    v.req = r; v.cscl = c; v.csda = d; v.si = si; v.di = di;
    v.grant = g; v.owner = o; v.busy = b; v.scl = s; v.sda = a;
    vt.push_back(v);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int cnt;
    int held;
    logic anyg;
    reset = 1'b1; request = '0; cscl = 4'hF; csda = 4'hF; scl_in = 1'b1; sda_in = 1'b1;
    step(); step();
    chk("reset_grant", 32'(grant), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_owner", 32'(owner), 0);
    chk("reset_timeout", 32'(timeout), 0);
    chk("reset_scl", 32'(scl_out), 1);
    chk("reset_sda", 32'(sda_out), 1);
    reset = 1'b0;

    //   req      cscl     csda     si    di    grant    own    busy  scl   sda
    add(4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b1);
    add(4'b0100, 4'b1011, 4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
    add(4'b0100, 4'b1111, 4'b1011, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);
    add(4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b1);
    add(4'b0000, 4'b1011, 4'b1011, 1'b1, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b1, 1'b1);
    add(4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b1, 1'b1);
    add(4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b1, 1'b1);
    add(4'b0011, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b1, 1'b1);
    add(4'b0011, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b1, 1'b1);
    add(4'b0011, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1);
    add(4'b0010, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b1);
    add(4'b0010, 4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b1);
    add(4'b0010, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b1);
    add(4'b0010, 4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b1);
    add(4'b0010, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b1);
    add(4'b0010, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b1);
    add(4'b0010, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b1);
    add(4'b0010, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b1);
    add(4'b0010, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b1);
    add(4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b1, 1'b1);

    foreach (vt[i]) begin
      request = vt[i].req; cscl = vt[i].cscl; csda = vt[i].csda;
      scl_in = vt[i].si; sda_in = vt[i].di;
      step();
      chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vt[i].grant));
      chk($sformatf("vec%0d_owner", i), 32'(owner), 32'(vt[i].owner));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].busy));
      chk($sformatf("vec%0d_scl", i), 32'(scl_out), 32'(vt[i].scl));
      chk($sformatf("vec%0d_sda", i), 32'(sda_out), 32'(vt[i].sda));
      chk($sformatf("vec%0d_timeout", i), 32'(timeout), 0);
    end
    cscl = 4'hF; csda = 4'hF; scl_in = 1'b1; sda_in = 1'b1;

    // Fairness: all four request, each releases after 10 granted cycles.
    do_reset();
    request = 4'hF;
    step();
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("fair%0d_grant", g), 32'(grant), 32'(1) << (g % 4));
      repeat (9) step();
      chk($sformatf("fair%0d_hold", g), 32'(grant), 32'(1) << (g % 4));
      request[g % 4] = 1'b0;
      step();
      cnt = 1;
      request = 4'hF;
      while (grant == 4'b0 && cnt < 50) begin step(); cnt++; end
      chk($sformatf("fair%0d_spacing", g), 32'(cnt), 6);
    end

    // Watchdog: client 1 never lets go.
    do_reset();
    request = 4'b0010;
    step();
    chk("wd_grant", 32'(grant), 32'b0010);
    held = 1;
    while (grant[1] && held < 300) begin
      step();
      if (grant[1]) begin
        held++;
        if (timeout) chk("wd_early_pulse", 32'(timeout), 0);
      end
    end
    chk("wd_held_cycles", 32'(held), 100);
    chk("wd_pulse", 32'(timeout), 1);
    request = 4'b1010;
    step();
    chk("wd_pulse_width", 32'(timeout), 0);
    cnt = 1;
    while (grant == 4'b0 && cnt < 50) begin step(); cnt++; end
    chk("wd_other_grant", 32'(grant), 32'b1000);
    chk("wd_other_latency", 32'(cnt), 5);
    request = 4'b0010;
    anyg = 1'b0;
    repeat (12) begin step(); anyg |= (grant != 4'b0); end
    chk("wd_lockout_holds", 32'(anyg), 0);
    request = 4'b0000;
    step();
    request = 4'b0010;
    cnt = 0;
    while (grant == 4'b0 && cnt < 20) begin step(); cnt++; end
    chk("wd_regrant", 32'(grant), 32'b0010);

    // Release on the very cycle the watchdog would fire.
    do_reset();
    request = 4'b0010;
    step();
    repeat (99) step();
    chk("sim_held_at_limit", 32'(grant), 32'b0010);
    request = 4'b0000;
    step();
    chk("sim_grant_dropped", 32'(grant), 0);
    chk("sim_no_timeout", 32'(timeout), 0);
    request = 4'b0010;
    cnt = 0;
    while (grant == 4'b0 && cnt < 20) begin
      step(); cnt++;
      if (timeout) chk("sim_late_timeout", 32'(timeout), 0);
    end
    chk("sim_no_lockout", 32'(grant), 32'b0010);

    // Reset while the owner is holding SDA low.
    do_reset();
    csda = 4'b1110;
    request = 4'b0001;
    step();
    chk("rst_mid_sda_low", 32'(sda_out), 0);
    reset = 1'b1;
    step();
    chk("rst_mid_sda", 32'(sda_out), 1);
    chk("rst_mid_grant", 32'(grant), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    reset = 1'b0;
    csda = 4'hF;
    request = 4'b0000;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_bus_arbiter.md
# i2c_bus_arbiter

Shares one physical I2C bus (SCL/SDA open-drain pair) between several I2C master clients, each of which owns its own I2C master engine with a request/grant handshake. Grants the bus round-robin, muxes the owner's open-drain drive onto the pins and enforces a bus-free gap between owners. A watchdog revokes a grant held too long. Sits between the per-device controllers (retimer, port expander, SCDC) and the top-level SCL/SDA pads.

## Interface
- CLIENT_COUNT, 4: number of requesters, 2..8.
- IDLE_GAP_CYCLES, 500: cycles the physical bus must be seen idle (SCL and SDA high) before the next grant.
- TIMEOUT_CYCLES, 0: maximum cycles one grant may be held; 0 disables the watchdog.
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high.
- request  input  CLIENT_COUNT  per-client bus request, level.
- grant  output  CLIENT_COUNT  per-client grant, one-hot or zero, registered.
- client_scl_output  input  CLIENT_COUNT  per-client SCL drive; 0 = pull low, 1 = release.
- client_sda_output  input  CLIENT_COUNT  per-client SDA drive; same encoding.
- scl_input  input  1  physical SCL level, already synchronised.
- sda_input  input  1  physical SDA level, already synchronised.
- scl_output  output  1  physical SCL drive; 0 = pull low, 1 = release.
- sda_output  output  1  physical SDA drive.
- busy  output  1  high while any grant is held.
- owner  output  $clog2(CLIENT_COUNT)  index of the current or last owner.
- timeout  output  1  one-cycle pulse when the watchdog revokes a grant.

## Operation
- States: IDLE, OWNED, GAP.
- IDLE: if any request[i] is high with lockout[i] clear, select the first such i searching pointer, pointer+1, ... with modulo wrap. Set grant[i] and owner=i; go to OWNED. Clear the hold counter.
- OWNED: the hold counter increments by 1 per cycle and saturates.
  - request[owner] low: drop grant, go to GAP.
  - TIMEOUT_CYCLES != 0 and hold counter == TIMEOUT_CYCLES-1 while the request is still high: drop grant, set lockout[owner], pulse timeout, go to GAP.
  - The request-low exit has priority over timeout in the same cycle; no lockout and no timeout pulse in that case.
- GAP: the gap counter increments while scl_input and sda_input are both 1, and clears to 0 on any cycle where either is 0. At IDLE_GAP_CYCLES-1 with the bus still idle, go to IDLE. On leaving OWNED, pointer = owner+1, wrapping to 0.
- Lockout: lockout[i] clears on any cycle where request[i] is low. A timed-out client must deassert request for at least 1 cycle before it is eligible again.
- Pin mux, combinational from registered state:
  - scl_output = client_scl_output[owner] and sda_output = client_sda_output[owner] when in OWNED.
  - Otherwise both outputs = 1 (released).
  - Non-owner drive inputs are ignored.
- busy = (state == OWNED).

## Timing
- Reset values:
  - state IDLE, grant 0, owner 0, pointer 0, lockout 0.
  - timeout 0, busy 0, scl_output 1, sda_output 1, both counters 0.
- Request to grant: request high at edge N, arbiter in IDLE → grant high after edge N+1 (1-cycle latency).
- Release: request[owner] low sampled at edge N → grant 0 and pins released after edge N+1.
- Minimum spacing between two grants: 1 + IDLE_GAP_CYCLES + 1 cycles, with the bus idle throughout.
- Timeout: grant held exactly TIMEOUT_CYCLES cycles. The timeout pulse coincides with the first cycle grant is 0.
- Simultaneous requests are resolved by the round-robin pointer only. A new request arriving during OWNED or GAP waits; it is not dropped.
- Reset mid-transfer: the next cycle has pins released, grant 0 and state IDLE. The half-finished transaction is abandoned; clients recover via their own reset.

## Structure
- Shared package i2c_pkg: the state enum, the open-drain drive encoding constants (DRIVE_LOW=0, RELEASE=1), and a CLIENT_INDEX_WIDTH helper function.
- One sub-module, round_robin_picker: combinational first-eligible search from the pointer, with one-hot output plus index and valid.
- The counters, lockout logic and pin mux stay in the top module.

## Test plan
All scenarios use CLIENT_COUNT=4, IDLE_GAP_CYCLES=4 and TIMEOUT_CYCLES=100.
- Single client: request[2]=1 → grant=4'b0100 one cycle later, owner=2, pins follow client 2. Drop request → grant=0 next cycle; pins=1.
- Fairness: request=4'b1111 held, each client drops after 10 cycles of grant → grant order 0,1,2,3,0 with ≥6 cycles between grants.
- Gap with bus activity: force scl_input=0 for 3 cycles during GAP → the gap counter restarts; the next grant comes no earlier than 4 idle cycles after SCL returns high.
- Watchdog: client 1 holds request for 200 cycles → grant[1] drops after exactly 100 cycles and the timeout pulse lasts 1 cycle. Client 1 is not regranted until request[1] goes low for 1 cycle; client 3 requesting meanwhile is granted after the gap.
- Simultaneous exit: request low on the same cycle the timeout is reached → no timeout pulse and no lockout.
- Reset while client 0 holds SDA low → sda_output=1, grant=0 and busy=0 on the cycle after reset.
